// File: rtl/transmissor_serial_registro.sv
// Serial transmitter: start bit, N data bits LSB first, optional even parity, stop bit.
// Define PARIDADE_EN to add the parity bit after the data bits.
module transmissor_serial_registro #(
  parameter int N   = 4,
  parameter int DIV = 4
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         partida,
  input  logic [N-1:0] dados,
  output logic         saida_serial,
  output logic         ocupado,
  output logic         pronto,
  output logic [2:0]   db_estado
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t         state;
  logic [N-1:0]   shift_reg;
  logic [N-1:0]   shift_nxt;
  logic [BW-1:0]  bit_cnt;
  logic [TW-1:0]  tick;
  logic           tick_end;
`ifdef PARIDADE_EN
  logic           par;
`endif

  assign tick_end  = (tick == TW'(DIV - 1));
  assign shift_nxt = shift_reg >> 1;
  assign db_estado = state;

  // Outputs are loaded together with the state they belong to, so the line
  // value is already valid in the first cycle of each bit.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      tick         <= '0;
      saida_serial <= 1'b1;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
`ifdef PARIDADE_EN
      par          <= 1'b0;
`endif
    end else begin
      pronto <= 1'b0;
      case (state)
        IDLE: begin
          if (partida) begin
            shift_reg    <= dados;
`ifdef PARIDADE_EN
            par          <= ^dados;
`endif
            bit_cnt      <= '0;
            tick         <= '0;
            state        <= START;
            saida_serial <= 1'b0;
            ocupado      <= 1'b1;
          end
        end
        START: begin
          if (tick_end) begin
            tick         <= '0;
            state        <= DATA;
            saida_serial <= shift_reg[0];
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick_end) begin
            tick      <= '0;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(N - 1)) begin
`ifdef PARIDADE_EN
              state        <= PARITY;
              saida_serial <= par;
`else
              state        <= STOP;
              saida_serial <= 1'b1;
`endif
            end else begin
              saida_serial <= shift_nxt[0];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef PARIDADE_EN
        PARITY: begin
          if (tick_end) begin
            tick         <= '0;
            state        <= STOP;
            saida_serial <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_end) begin
            tick    <= '0;
            state   <= DONE;
            ocupado <= 1'b0;
            pronto  <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          saida_serial <= 1'b1;
          ocupado      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_serial_registro.sv
// Bench for transmissor_serial_registro: frame-level model checked every cycle
// on a DIV=4 and a DIV=1 instance, plus literal line/pronto expectations.
module tb_transmissor_serial_registro;

`ifdef PARIDADE_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 6 + P;          // bit slots per frame for N=4
  localparam int F4 = NB * 4;
  localparam int F1 = NB * 1;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       partida = 1'b0, partida1 = 1'b0;
  logic [3:0] dados = 4'b0, dados1 = 4'b0;
  logic       saida, ocup, pron;
  logic [2:0] est;
  logic       saida1, ocup1, pron1;
  logic [2:0] est1;

  int compared = 0;
  int mismatched = 0;
  logic chk_on = 1'b0;

  always #5 clock = ~clock;

  transmissor_serial_registro #(.N(4), .DIV(4)) dut (
    .clock(clock), .clear_n(clear_n), .partida(partida), .dados(dados),
    .saida_serial(saida), .ocupado(ocup), .pronto(pron), .db_estado(est));

  transmissor_serial_registro #(.N(4), .DIV(1)) dut1 (
    .clock(clock), .clear_n(clear_n), .partida(partida1), .dados(dados1),
    .saida_serial(saida1), .ocupado(ocup1), .pronto(pron1), .db_estado(est1));

  task automatic check(input string name, input int act, input int expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Frame model: cyc counts cycles since the accepting edge (0 = idle).
  function automatic void expect_out(input int cyc, input logic [3:0] w, input int div,
                                     output logic line, output logic oc, output logic pr,
                                     output logic [2:0] st);
    int f, slot;
    f = NB * div;
    line = 1'b1; oc = 1'b0; pr = 1'b0; st = 3'd0;
    if (cyc >= 1 && cyc <= f) begin
      oc = 1'b1;
      slot = (cyc - 1) / div;
      if (slot == 0) begin
        line = 1'b0; st = 3'd1;
      end else if (slot <= 4) begin
        line = w[slot-1]; st = 3'd2;
      end else if (slot == 5 && P == 1) begin
        line = ^w; st = 3'd3;
      end else begin
        line = 1'b1; st = 3'd4;
      end
    end else if (cyc == f + 1) begin
      pr = 1'b1; st = 3'd5;
    end
  endfunction

  int m_cyc = 0, m_cyc1 = 0;
  logic [3:0] m_word = 4'b0, m_word1 = 4'b0;

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) m_cyc <= 0;
    else if (m_cyc == 0) begin
      if (partida) begin m_cyc <= 1; m_word <= dados; end
    end else if (m_cyc >= F4 + 1) m_cyc <= 0;
    else m_cyc <= m_cyc + 1;
  end

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) m_cyc1 <= 0;
    else if (m_cyc1 == 0) begin
      if (partida1) begin m_cyc1 <= 1; m_word1 <= dados1; end
    end else if (m_cyc1 >= F1 + 1) m_cyc1 <= 0;
    else m_cyc1 <= m_cyc1 + 1;
  end

  always @(negedge clock) begin
    logic l, o, p;
    logic [2:0] s;
    if (chk_on) begin
      expect_out(m_cyc, m_word, 4, l, o, p, s);
      check("m4_line", saida, l);
      check("m4_ocupado", ocup, o);
      check("m4_pronto", pron, p);
      check("m4_estado", est, s);
      expect_out(m_cyc1, m_word1, 1, l, o, p, s);
      check("m1_line", saida1, l);
      check("m1_ocupado", ocup1, o);
      check("m1_pronto", pron1, p);
      check("m1_estado", est1, s);
    end
  end

  logic rec_line [0:F4+2];
  logic rec_pr   [0:F4+2];
  logic rec_oc   [0:F4+2];

  // One DIV=4 frame; lit holds the expected line per bit slot, LSB = start bit.
  task automatic run_frame4(input logic [3:0] w, input logic [6:0] lit,
                            input string tag, input bit inject);
    @(negedge clock);
    dados = w; partida = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= F4 + 2; c++) begin
      @(negedge clock);
      if (c == 1) partida = 1'b0;
      if (inject && c == 10) begin partida = 1'b1; dados = 4'b0000; end
      if (inject && c == 11) partida = 1'b0;
      rec_line[c] = saida; rec_pr[c] = pron; rec_oc[c] = ocup;
    end
    for (int k = 0; k < NB; k++)
      check($sformatf("%s_slot%0d", tag, k), rec_line[4*k+2], lit[k]);
    check({tag, "_pronto_end"}, rec_pr[F4+1], 1);
    check({tag, "_pronto_early"}, rec_pr[F4], 0);
    check({tag, "_ocup_first"}, rec_oc[1], 1);
    check({tag, "_ocup_last"}, rec_oc[F4], 1);
    check({tag, "_ocup_done"}, rec_oc[F4+1], 0);
  endtask

  initial begin
    int last, n_pulse;
    // Reset held with partida high: nothing may start.
    dados = 4'b1011; partida = 1'b1; partida1 = 1'b1;
    @(posedge clock);
    chk_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("rst_line", saida, 1);
      check("rst_ocupado", ocup, 0);
      check("rst_pronto", pron, 0);
      check("rst_estado", est, 0);
    end
    partida = 1'b0; partida1 = 1'b0; clear_n = 1'b1;
    repeat (2) @(negedge clock);

    run_frame4(4'b1011, 7'b1110110, "basic", 1'b0);
`ifdef PARIDADE_EN
    run_frame4(4'b0011, 7'b1000110, "par0011", 1'b0);
`else
    run_frame4(4'b0011, 7'b0100110, "f0011", 1'b0);
`endif
    // partida and dados disturbed mid-frame must not matter.
    run_frame4(4'b1011, 7'b1110110, "ignore", 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("no_second_frame", ocup, 0);
    end

    // Reset in the second data bit (cycle 10).
    @(negedge clock);
    dados = 4'b1011; partida = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 1) partida = 1'b0;
    end
    #2 clear_n = 1'b0;
    #1;
    check("midrst_line", saida, 1);
    check("midrst_estado", est, 0);
    check("midrst_ocupado", ocup, 0);
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
`ifdef PARIDADE_EN
    run_frame4(4'b0110, 7'b1001100, "after_rst", 1'b0);
`else
    run_frame4(4'b0110, 7'b0101100, "after_rst", 1'b0);
`endif

    // DIV=1 back-to-back frames with partida held high.
    @(negedge clock);
    dados1 = 4'b0101; partida1 = 1'b1;
    last = -1; n_pulse = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      if (pron1) begin
        if (last >= 0) check("b2b_period", c - last, F1 + 2);
        last = c; n_pulse++;
      end
    end
    check("b2b_pulses", n_pulse, 45 / (F1 + 2));
    partida1 = 1'b0;
    repeat (12) @(negedge clock);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
